// File: rtl/sprdma_pkg.sv
// ----------------------------------------------------------------------------
// sprdma_pkg
// Shared definitions for the sprite DMA engine: FSM state encoding, the
// trigger register address, the OAM data port address and transfer length.
// ----------------------------------------------------------------------------
package sprdma_pkg;

    // Transfer sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_READ  = 3'd2,
        ST_LATCH = 3'd3,
        ST_WRITE = 3'd4
    } sprdma_state_t;

    localparam logic [15:0] SPRDMA_TRIG_ADDR = 16'h4014;
    localparam logic [15:0] OAMDATA_ADDR     = 16'h2004;
    localparam int          SPRDMA_BYTES     = 256;

    // Index of the final byte of a transfer.
    localparam logic [7:0]  SPRDMA_LAST_BYTE = 8'(SPRDMA_BYTES - 1);

endpackage : sprdma_pkg

// File: rtl/sprdma.sv
// ----------------------------------------------------------------------------
// sprdma
// Sprite DMA engine. Snoops CPU writes to 16'h4014; the written byte selects a
// source page whose 256 bytes are copied, one byte at a time, to the OAM data
// port at 16'h2004. Each byte takes three cycles (READ, LATCH, WRITE) after a
// single START cycle, so a transfer owns the bus for 769 cycles.
//
// Ports
//   clk_in          system clock
//   nrst_in         asynchronous active-low reset
//   cpu_a_in        snooped CPU address bus
//   cpu_d_in        snooped CPU write data (source page on trigger)
//   cpu_r_nw_in     snooped CPU read/write select (1 = read)
//   hold_in         freeze request from the debug interface
//   cpumc_d_in      read data from the CPU memory bus
//   active_out      block owns the CPU memory bus
//   cpumc_a_out     memory bus address during a transfer
//   cpumc_d_out     memory bus write data
//   cpumc_r_nw_out  memory bus read/write select (1 = read)
// ----------------------------------------------------------------------------
module sprdma
    import sprdma_pkg::*;
(
    input  logic        clk_in,
    input  logic        nrst_in,
    input  logic [15:0] cpu_a_in,
    input  logic [7:0]  cpu_d_in,
    input  logic        cpu_r_nw_in,
    input  logic        hold_in,
    input  logic [7:0]  cpumc_d_in,
    output logic        active_out,
    output logic [15:0] cpumc_a_out,
    output logic [7:0]  cpumc_d_out,
    output logic        cpumc_r_nw_out
);

    sprdma_state_t state;
    logic [7:0]    page;
    logic [7:0]    cnt;
    logic [7:0]    data;
    logic          prev_match;

    logic          match;
    logic          trigger;

    // A CPU write to the trigger register. Only the first cycle of a match
    // counts, so a long CPU write cycle cannot start a second transfer.
    assign match   = (cpu_a_in == SPRDMA_TRIG_ADDR) && !cpu_r_nw_in;
    assign trigger = match && !prev_match && (state == ST_IDLE) && !hold_in;

    // NOTE: every register, including the datapath bytes, is cleared by the
    // asynchronous reset so an aborted transfer leaves no stale page or data.
    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            state      <= ST_IDLE;
            page       <= 8'h00;
            cnt        <= 8'h00;
            data       <= 8'h00;
            prev_match <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, independent of statement order.
            // The edge detector keeps tracking the CPU during hold, so a write
            // that straddles a hold window is not seen as a fresh edge later.
            prev_match <= match;
            if (!hold_in) begin
                case (state)
                    ST_IDLE: begin
                        if (trigger) begin
                            page  <= cpu_d_in;
                            cnt   <= 8'h00;
                            state <= ST_START;
                        end
                    end
                    // Lets the triggering CPU write cycle retire before the
                    // bus is taken over.
                    ST_START: state <= ST_READ;
                    ST_READ:  state <= ST_LATCH;
                    // Memory returns read data one cycle after the address,
                    // so the byte is captured at the end of LATCH.
                    ST_LATCH: begin
                        data  <= cpumc_d_in;
                        state <= ST_WRITE;
                    end
                    // 8-bit wrap: the source address never carries into page.
                    ST_WRITE: begin
                        cnt   <= cnt + 8'h01;
                        state <= (cnt == SPRDMA_LAST_BYTE) ? ST_IDLE : ST_READ;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Bus outputs decode directly from the registered state, so they freeze
    // with it during hold and fall to idle values the moment reset asserts.
    always_comb begin
        // NOTE: defaults first so no path through the case infers a latch.
        active_out     = 1'b1;
        cpumc_a_out    = 16'h0000;
        cpumc_d_out    = 8'h00;
        cpumc_r_nw_out = 1'b1;
        case (state)
            ST_IDLE:  active_out = 1'b0;
            ST_START: ;
            ST_READ,
            ST_LATCH: cpumc_a_out = {page, cnt};
            ST_WRITE: begin
                cpumc_a_out    = OAMDATA_ADDR;
                cpumc_d_out    = data;
                cpumc_r_nw_out = 1'b0;
            end
            default:  active_out = 1'b0;
        endcase
    end

endmodule : sprdma

// File: tb/tb_sprdma.sv
// ----------------------------------------------------------------------------
// tb_sprdma
// Scoreboard bench for sprdma: each transfer pushes its expected OAM write
// bytes into a queue; an independent monitor pops and compares every write
// the DUT presents. A small synchronous memory model answers reads.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sprdma;

    logic        clk_in = 1'b0;
    logic        nrst_in = 1'b0;
    logic [15:0] cpu_a_in = 16'h0000;
    logic [7:0]  cpu_d_in = 8'h00;
    logic        cpu_r_nw_in = 1'b1;
    logic        hold_in = 1'b0;
    logic [7:0]  cpumc_d_in;
    logic        active_out;
    logic [15:0] cpumc_a_out;
    logic [7:0]  cpumc_d_out;
    logic        cpumc_r_nw_out;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_q [$];
    int          act_cnt = 0;
    logic [15:0] last_rd = 16'h0000;
    bit          seen_zero = 1'b0;
    bit          prev_act = 1'b0;

    logic [7:0]  mem [0:65535];
    logic [7:0]  rd_q = 8'h00;

    always #5 clk_in = ~clk_in;

    sprdma dut (
        .clk_in         (clk_in),
        .nrst_in        (nrst_in),
        .cpu_a_in       (cpu_a_in),
        .cpu_d_in       (cpu_d_in),
        .cpu_r_nw_in    (cpu_r_nw_in),
        .hold_in        (hold_in),
        .cpumc_d_in     (cpumc_d_in),
        .active_out     (active_out),
        .cpumc_a_out    (cpumc_a_out),
        .cpumc_d_out    (cpumc_d_out),
        .cpumc_r_nw_out (cpumc_r_nw_out)
    );

    // Synchronous-read memory: data appears the cycle after the address.
    always @(posedge clk_in) rd_q <= mem[cpumc_a_out];
    assign cpumc_d_in = rd_q;

    // Page 02 holds its own index; every other page holds a scrambled pattern.
    function automatic logic [7:0] mem_val(input logic [15:0] a);
        if (a[15:8] == 8'h02) return a[7:0];
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: scoreboard for OAM writes plus read-address bookkeeping.
    initial begin
        forever begin
            @(negedge clk_in);
            if (nrst_in && active_out) begin
                act_cnt++;
                if (!cpumc_r_nw_out) begin
                    check("oam_wr_addr", 32'(cpumc_a_out), 32'(16'h2004));
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL oam_wr_unexpected: got data %0h expected no write at %0t",
                                 cpumc_d_out, $time);
                    end else begin
                        check("oam_wr_data", 32'(cpumc_d_out), 32'(exp_q.pop_front()));
                    end
                end else if (prev_act) begin
                    last_rd = cpumc_a_out;
                    if (cpumc_a_out == 16'h0000) seen_zero = 1'b1;
                end
            end
            prev_act = nrst_in && active_out;
        end
    end

    task automatic bus_idle();
        cpu_a_in    = 16'h0000;
        cpu_d_in    = 8'h00;
        cpu_r_nw_in = 1'b1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_active"}, 32'(active_out), 32'd0);
        check({tag, "_addr"},   32'(cpumc_a_out), 32'd0);
        check({tag, "_data"},   32'(cpumc_d_out), 32'd0);
        check({tag, "_rnw"},    32'(cpumc_r_nw_out), 32'd1);
    endtask

    // One triggered transfer. hold_at / abort_at >= 0 select a byte at which
    // to freeze (10 cycles, starting in its LATCH cycle) or to pulse reset.
    task automatic run_dma(input string tag, input logic [7:0] page, input int trig_cycles,
                           input int hold_at, input int abort_at, input int exp_cycles);
        int  n;
        int  sight;
        bit  seen;
        bit  done;
        logic [25:0] snap;
        for (int i = 0; i < 256; i++) exp_q.push_back(mem_val({page, 8'(i)}));
        act_cnt   = 0;
        seen_zero = 1'b0;
        last_rd   = 16'h0000;
        n = 0; sight = 0; seen = 1'b0; done = 1'b0;
        @(negedge clk_in);
        cpu_a_in    = 16'h4014;
        cpu_d_in    = page;
        cpu_r_nw_in = 1'b0;
        while (!done) begin
            @(negedge clk_in);
            n++;
            if (n == trig_cycles) bus_idle();
            if (active_out) seen = 1'b1;
            if (seen && !active_out) begin
                done = 1'b1;
            end else if (!seen && n > 5) begin
                check({tag, "_start_timeout"}, 32'(active_out), 32'd1);
                done = 1'b1;
            end else if (n > 3000) begin
                check({tag, "_end_timeout"}, 32'(active_out), 32'd0);
                done = 1'b1;
            end else if (active_out && cpumc_r_nw_out && cpumc_a_out == {page, 8'(hold_at)}
                         && hold_at >= 0) begin
                sight++;
                if (sight == 2) begin
                    hold_in = 1'b1;
                    snap = {active_out, cpumc_a_out, cpumc_r_nw_out, cpumc_d_out};
                    for (int k = 0; k < 10; k++) begin
                        @(negedge clk_in);
                        check({tag, "_frozen"},
                              32'({active_out, cpumc_a_out, cpumc_r_nw_out, cpumc_d_out}),
                              32'(snap));
                    end
                    hold_in = 1'b0;
                end
            end else if (abort_at >= 0 && active_out && cpumc_r_nw_out
                         && cpumc_a_out == {page, 8'(abort_at)}) begin
                nrst_in = 1'b0;
                #1;
                check_idle_outputs({tag, "_abort"});
                check({tag, "_abort_pending"}, 32'(exp_q.size()), 32'(256 - abort_at));
                exp_q.delete();
                bus_idle();
                repeat (3) @(negedge clk_in);
                check_idle_outputs({tag, "_in_reset"});
                nrst_in = 1'b1;
                repeat (2) @(negedge clk_in);
                return;
            end
        end
        bus_idle();
        check({tag, "_own_cycles"}, 32'(act_cnt), 32'(exp_cycles));
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_last_rd"}, 32'(last_rd), 32'({page, 8'hFF}));
        check({tag, "_no_rd_0000"}, 32'(seen_zero), 32'd0);
        exp_q.delete();
        act_cnt = 0;
        repeat (20) @(negedge clk_in);
        check({tag, "_no_retrigger"}, 32'(act_cnt), 32'd0);
        check_idle_outputs({tag, "_after"});
    endtask

    // Bus activity that must not start a transfer.
    task automatic no_trigger(input string tag, input logic [15:0] a, input logic rnw,
                              input logic hold);
        act_cnt = 0;
        @(negedge clk_in);
        cpu_a_in    = a;
        cpu_d_in    = 8'h02;
        cpu_r_nw_in = rnw;
        hold_in     = hold;
        @(negedge clk_in);
        bus_idle();
        hold_in = 1'b0;
        repeat (10) @(negedge clk_in);
        check({tag, "_no_active"}, 32'(act_cnt), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = mem_val(16'(i));
        #2;
        check_idle_outputs("reset");
        repeat (3) @(negedge clk_in);
        check_idle_outputs("reset_held");
        nrst_in = 1'b1;
        repeat (2) @(negedge clk_in);

        run_dma("page02", 8'h02, 1, -1, -1, 769);
        run_dma("pageFF", 8'hFF, 1, -1, -1, 769);
        run_dma("long_trig_page20", 8'h20, 50, -1, -1, 769);
        run_dma("hold80", 8'h03, 1, 8'h80, -1, 779);
        run_dma("abort40", 8'h04, 1, -1, 8'h40, 0);
        run_dma("after_abort", 8'h05, 1, -1, -1, 769);

        no_trigger("wr4015", 16'h4015, 1'b0, 1'b0);
        no_trigger("rd4014", 16'h4014, 1'b1, 1'b0);
        no_trigger("hold_trig", 16'h4014, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_sprdma

// File: doc/sprdma.md
SPRDMA -- requirements
Module: sprdma

Interface
REQ-001 clk_in  input  1  system clock, 100 MHz; the block's only clock.
REQ-002 nrst_in  input  1  reset, asynchronous, active-low.
REQ-003 cpu_a_in  input  16  address bus of the rp2a03 CPU, snooped for trigger detection.
REQ-004 cpu_d_in  input  8  write data of the rp2a03 CPU; supplies the source page on trigger.
REQ-005 cpu_r_nw_in  input  1  read/write select of the rp2a03 CPU (1 = read).
REQ-006 hold_in  input  1  freeze request, driven high while the host debug interface owns the bus.
REQ-007 cpumc_d_in  input  8  read data returned from the CPU memory bus (OR of wram, cart PRG and PPU register outputs).
REQ-008 active_out  output  1  block owns the CPU memory bus; top level muxes cpumc_* from this block and deasserts CPU rdy.
REQ-009 cpumc_a_out  output  16  CPU memory bus address driven during a transfer.
REQ-010 cpumc_d_out  output  8  CPU memory bus write data.
REQ-011 cpumc_r_nw_out  output  1  CPU memory bus read/write select (1 = read).

Function
REQ-012 Trigger: CPU write to 16'h4014 (cpu_r_nw_in=0), detected only on the first clock of a match (registered previous-match flag) and only in IDLE.
REQ-013 On trigger, page register <= cpu_d_in, byte counter <= 0, and the FSM enters START.
REQ-014 FSM states: IDLE, START, READ, LATCH, WRITE.
REQ-015 IDLE -> START on trigger; otherwise the FSM stays in IDLE.
REQ-016 START -> READ after one cycle; START gives the CPU write cycle time to retire.
REQ-017 READ: cpumc_a_out = {page, cnt}, cpumc_r_nw_out = 1; next state LATCH.
REQ-018 LATCH: address held as in READ; data register <= cpumc_d_in at the end of the cycle, which covers the one-cycle synchronous memory read latency; next state WRITE.
REQ-019 WRITE: cpumc_a_out = 16'h2004, cpumc_r_nw_out = 0, cpumc_d_out = data register; cnt increments.
REQ-020 WRITE -> IDLE if cnt == 8'hFF, else WRITE -> READ.
REQ-021 Counter arithmetic is 8-bit; the source address never carries into the page byte (page FF reads FF00..FFFF only).
REQ-022 active_out = 1 in START, READ, LATCH and WRITE; 0 in IDLE.
REQ-023 Transfer length is exactly 256 writes to 16'h2004; total bus ownership is exactly 769 cycles (1 + 256 x 3), excluding any hold cycles.
REQ-024 Outside WRITE, cpumc_r_nw_out = 1; outside READ, LATCH and WRITE, cpumc_a_out = 0 and cpumc_d_out = 0.
REQ-025 hold_in = 1 freezes state, counter, page and data registers; outputs keep their current values; the transfer resumes unchanged when hold_in falls.
REQ-026 A trigger match while not in IDLE is ignored and does not restart or extend the transfer.
REQ-027 A trigger coincident with hold_in = 1 in IDLE is ignored.
REQ-028 Any source page is legal; page 8'h20 reads PPU registers and has no special case.

Reset
REQ-029 nrst_in low asynchronously forces: state IDLE, cnt 0, page 0, data 0, previous-match flag 0, active_out 0, cpumc_a_out 0, cpumc_d_out 0, cpumc_r_nw_out 1.
REQ-030 Reset mid-transfer aborts the transfer immediately; no partial write completes after reset is asserted.
REQ-031 After reset release, the first trigger is accepted only when a fresh match edge occurs.

Structure
REQ-032 A shared package holds the state encoding, SPRDMA_TRIG_ADDR (16'h4014), OAMDATA_ADDR (16'h2004) and SPRDMA_BYTES (256).
REQ-033 The block is a single flat module with no sub-module; the edge detect and FSM live in one always block plus output decode.

Verification
REQ-034 Write 8'h02 to 16'h4014 with wram at 0200..02FF = index -> 256 writes to 16'h2004 with data 00..FF in order, and active_out high for 769 cycles.
REQ-035 Page 8'hFF -> last read address 16'hFFFF, no access at 16'h0000, and FSM returns to IDLE.
REQ-036 Hold the trigger write for 50 cycles -> exactly one transfer, with no retrigger.
REQ-037 Assert hold_in for 10 cycles at byte 8'h80 LATCH -> outputs frozen, then 8'h80 data written once, and total ownership 779 cycles.
REQ-038 Pulse nrst_in low at byte 8'h40 -> active_out 0 within the same cycle, all outputs at reset values, and a subsequent trigger performs a full 256-byte transfer.
REQ-039 Write to 16'h4015 or read from 16'h4014 -> active_out stays 0.
